// File: rtl/watch_set.sv
// watch_set: interactive date/time editor with field wrap, day clamp and inactivity timeout
// Ports: clk, rst (async active-high); clk1sec once-per-second pulse;
//    key_mode/key_up/key_down debounced one-clk pulses; cur_time live time in;
//    bin_time edited time out; set_time one-clk commit strobe; edit_active/edit_field status.
module watch_set #(
   parameter int TIMEOUT_SEC = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk1sec,
   input  logic        key_mode,
   input  logic        key_up,
   input  logic        key_down,
   input  logic [51:0] cur_time,
   output logic [51:0] bin_time,
   output logic        set_time,
   output logic        edit_active,
   output logic [2:0]  edit_field
);
   localparam int CW = $clog2(TIMEOUT_SEC + 1);
   typedef enum logic [2:0] {IDLE, YEAR, MONTH, DAY, HOUR, MINUTE, SECOND, COMMIT} state_t;
   state_t        r_state, w_nxt;
   logic [11:0]   r_year, w_year_n, w_cy;
   logic [7:0]    r_month, r_day, r_hour, r_min, r_sec;
   logic [7:0]    w_month_n, w_day_s, w_day_n, w_hour_n, w_min_n, w_sec_n, w_max;
   logic [7:0]    w_cmo, w_cd, w_ch, w_cmi, w_cs;
   logic [CW-1:0] r_cnt;
   logic          r_set_time, r_edit_active;
   logic          w_ld, w_inc, w_dec, w_key, w_edit, w_tick, w_tmo;

   function automatic logic [7:0] max_day(input logic [11:0] y, input logic [7:0] m);
      logic leap;
      leap = ((y % 12'd4) == 12'd0 && (y % 12'd100) != 12'd0) || (y % 12'd400) == 12'd0;
      return (m == 8'd2) ? (leap ? 8'd29 : 8'd28)
           : (m == 8'd4 || m == 8'd6 || m == 8'd9 || m == 8'd11) ? 8'd30 : 8'd31;
   endfunction

   assign {w_cy, w_cmo, w_cd, w_ch, w_cmi, w_cs} = cur_time;
   assign w_ld   = (r_state == IDLE) && key_mode;
   assign w_inc  = key_up && !key_down && !key_mode;
   assign w_dec  = key_down && !key_up && !key_mode;
   assign w_key  = key_mode || key_up || key_down;
   assign w_edit = (r_state != IDLE) && (r_state != COMMIT);
   assign w_tick = w_edit && clk1sec;
   // A key in the same clk as the final tick wins, so the timeout needs a key-free clk
   assign w_tmo  = w_tick && !w_key && (r_cnt == CW'(TIMEOUT_SEC - 1));

   // Loaded values are coerced into range so no field can ever leave its legal span
   assign w_year_n  = w_ld ? ((w_cy == 12'd0) ? 12'd1 : w_cy)
                    : (r_state != YEAR) ? r_year
                    : w_inc ? ((r_year == 12'd4095) ? 12'd1 : r_year + 12'd1)
                    : w_dec ? ((r_year <= 12'd1) ? 12'd4095 : r_year - 12'd1)
                    : r_year;
   assign w_month_n = w_ld ? ((w_cmo == 8'd0 || w_cmo > 8'd12) ? 8'd1 : w_cmo)
                    : (r_state != MONTH) ? r_month
                    : w_inc ? ((r_month >= 8'd12) ? 8'd1 : r_month + 8'd1)
                    : w_dec ? ((r_month <= 8'd1) ? 8'd12 : r_month - 8'd1)
                    : r_month;
   // Month length follows the post-edit year/month, so the clamp lands in the same clk
   assign w_max     = max_day(w_year_n, w_month_n);
   assign w_day_s   = w_ld ? ((w_cd == 8'd0) ? 8'd1 : w_cd)
                    : (r_state != DAY) ? r_day
                    : w_inc ? ((r_day >= w_max) ? 8'd1 : r_day + 8'd1)
                    : w_dec ? ((r_day <= 8'd1) ? w_max : r_day - 8'd1)
                    : r_day;
   assign w_day_n   = (w_day_s > w_max) ? w_max : w_day_s;
   assign w_hour_n  = w_ld ? ((w_ch > 8'd23) ? 8'd0 : w_ch)
                    : (r_state != HOUR) ? r_hour
                    : w_inc ? ((r_hour >= 8'd23) ? 8'd0 : r_hour + 8'd1)
                    : w_dec ? ((r_hour == 8'd0) ? 8'd23 : r_hour - 8'd1)
                    : r_hour;
   assign w_min_n   = w_ld ? ((w_cmi > 8'd59) ? 8'd0 : w_cmi)
                    : (r_state != MINUTE) ? r_min
                    : w_inc ? ((r_min >= 8'd59) ? 8'd0 : r_min + 8'd1)
                    : w_dec ? ((r_min == 8'd0) ? 8'd59 : r_min - 8'd1)
                    : r_min;
   assign w_sec_n   = w_ld ? ((w_cs > 8'd59) ? 8'd0 : w_cs)
                    : (r_state != SECOND) ? r_sec
                    : w_inc ? ((r_sec >= 8'd59) ? 8'd0 : r_sec + 8'd1)
                    : w_dec ? ((r_sec == 8'd0) ? 8'd59 : r_sec - 8'd1)
                    : r_sec;

   // Field states are numbered consecutively, so advancing is a plain increment (SECOND+1 = COMMIT)
   assign w_nxt = (r_state == IDLE) ? (key_mode ? YEAR : IDLE)
                : (r_state == COMMIT) ? IDLE
                : key_mode ? state_t'(r_state + 3'd1)
                : w_tmo ? IDLE
                : r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_set_time    <= 1'b0;
         r_edit_active <= 1'b0;
         r_cnt         <= '0;
         r_year        <= 12'd2021;
         r_month       <= 8'd6;
         r_day         <= 8'd2;
         r_hour        <= 8'd6;
         r_min         <= 8'd0;
         r_sec         <= 8'd0;
      end else begin
         r_state       <= w_nxt;
         r_set_time    <= (w_nxt == COMMIT);
         r_edit_active <= (w_nxt != IDLE);
         r_cnt         <= (w_key || !w_edit || w_tmo) ? '0 : w_tick ? r_cnt + CW'(1) : r_cnt;
         r_year        <= w_year_n;
         r_month       <= w_month_n;
         r_day         <= w_day_n;
         r_hour        <= w_hour_n;
         r_min         <= w_min_n;
         r_sec         <= w_sec_n;
      end
   end

   assign bin_time    = {r_year, r_month, r_day, r_hour, r_min, r_sec};
   assign set_time    = r_set_time;
   assign edit_active = r_edit_active;
   assign edit_field  = r_state;
endmodule

// File: tb/tb_watch_set.sv
// tb_watch_set: vector table, directed sequences and randomized run against a date-arithmetic model
module tb_watch_set;
   localparam int TO = 6;
   logic        clk = 1'b0;
   logic        rst, clk1sec, key_mode, key_up, key_down;
   logic [51:0] cur_time, bin_time;
   logic        set_time, edit_active;
   logic [2:0]  edit_field;
   int          n_tests = 0;
   int          n_fail = 0;
   int          m_st, m_cnt;
   int          m_f[7];

   watch_set #(.TIMEOUT_SEC(TO)) dut (
      .clk(clk), .rst(rst), .clk1sec(clk1sec), .key_mode(key_mode), .key_up(key_up),
      .key_down(key_down), .cur_time(cur_time), .bin_time(bin_time), .set_time(set_time),
      .edit_active(edit_active), .edit_field(edit_field)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [51:0] start;
      int          field;
      bit          up;
      bit          dn;
      logic [51:0] exp;
   } vec_t;
   vec_t vt[17];

   function automatic logic [51:0] pk(int y, int mo, int d, int h, int mi, int s);
      return {12'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
   endfunction

   function automatic int dim(int y, int m);
      if (m == 2) return ((y % 4 == 0 && y % 100 != 0) || y % 400 == 0) ? 29 : 28;
      return (m == 4 || m == 6 || m == 9 || m == 11) ? 30 : 31;
   endfunction

   function automatic int lo_of(int i);
      return (i <= 3) ? 1 : 0;
   endfunction

   function automatic int hi_of(int i);
      return (i == 1) ? 4095 : (i == 2) ? 12 : (i == 3) ? dim(m_f[1], m_f[2]) : (i == 4) ? 23 : 59;
   endfunction

   function automatic logic [56:0] mexp();
      return {m_st == 7, m_st != 0, 3'(m_st), pk(m_f[1], m_f[2], m_f[3], m_f[4], m_f[5], m_f[6])};
   endfunction

   task automatic model_reset();
      m_st = 0;
      m_cnt = 0;
      m_f = '{0, 2021, 6, 2, 6, 0, 0};
   endtask

   task automatic model_step(input bit km, input bit ku, input bit kd, input bit tk, input logic [51:0] cur);
      bit key;
      int lo, sp;
      key = km | ku | kd;
      if (m_st == 0) begin
         if (km) begin
            m_f[1] = int'(cur[51:40]);
            m_f[2] = int'(cur[39:32]);
            m_f[3] = int'(cur[31:24]);
            m_f[4] = int'(cur[23:16]);
            m_f[5] = int'(cur[15:8]);
            m_f[6] = int'(cur[7:0]);
            m_st = 1;
         end
      end else if (m_st == 7) begin
         m_st = 0;
      end else if (km) begin
         m_st = m_st + 1;
      end else begin
         if (ku != kd) begin
            lo = lo_of(m_st);
            sp = hi_of(m_st) - lo + 1;
            m_f[m_st] = lo + (m_f[m_st] - lo + (ku ? 1 : sp - 1)) % sp;
            if (m_st <= 2 && m_f[3] > dim(m_f[1], m_f[2])) m_f[3] = dim(m_f[1], m_f[2]);
         end
         if (!key && tk) begin
            m_cnt = m_cnt + 1;
            if (m_cnt >= TO) begin
               m_st = 0;
               m_cnt = 0;
            end
         end
      end
      if (key) m_cnt = 0;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input bit km, input bit ku, input bit kd, input bit tk);
      key_mode = km;
      key_up = ku;
      key_down = kd;
      clk1sec = tk;
      model_step(km, ku, kd, tk, cur_time);
      @(posedge clk);
      #1;
      key_mode = 1'b0;
      key_up = 1'b0;
      key_down = 1'b0;
      clk1sec = 1'b0;
      chk("model", {7'd0, set_time, edit_active, edit_field, bin_time}, {7'd0, mexp()});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      key_mode = 1'b0;
      key_up = 1'b0;
      key_down = 1'b0;
      clk1sec = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   function automatic logic [51:0] rand_time();
      int y, mo, sel;
      sel = int'($urandom_range(0, 7));
      y = (sel == 0) ? 1 : (sel == 1) ? 4095 : (sel == 2) ? 2000 : (sel == 3) ? 2100 : int'($urandom_range(1, 4095));
      mo = int'($urandom_range(1, 12));
      return pk(y, mo, int'($urandom_range(1, dim(y, mo))), int'($urandom_range(0, 23)),
                int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
   endfunction

   localparam logic [51:0] RST_BIN = {12'd2021, 8'd6, 8'd2, 8'd6, 8'd0, 8'd0};

   initial begin
      int pulses, rate;
      vt[0]  = '{pk(2023, 1, 31, 6, 0, 0), 2, 1'b1, 1'b0, pk(2023, 2, 28, 6, 0, 0)};
      vt[1]  = '{pk(2024, 1, 31, 6, 0, 0), 2, 1'b1, 1'b0, pk(2024, 2, 29, 6, 0, 0)};
      vt[2]  = '{pk(2100, 1, 31, 6, 0, 0), 2, 1'b1, 1'b0, pk(2100, 2, 28, 6, 0, 0)};
      vt[3]  = '{pk(2021, 6, 2, 6, 59, 0), 5, 1'b1, 1'b0, pk(2021, 6, 2, 6, 0, 0)};
      vt[4]  = '{pk(2021, 6, 2, 0, 10, 0), 4, 1'b0, 1'b1, pk(2021, 6, 2, 23, 10, 0)};
      vt[5]  = '{pk(4095, 6, 2, 6, 0, 0), 1, 1'b1, 1'b0, pk(1, 6, 2, 6, 0, 0)};
      vt[6]  = '{pk(2021, 1, 31, 6, 0, 0), 2, 1'b0, 1'b1, pk(2021, 12, 31, 6, 0, 0)};
      vt[7]  = '{pk(2021, 4, 1, 6, 0, 0), 3, 1'b0, 1'b1, pk(2021, 4, 30, 6, 0, 0)};
      vt[8]  = '{pk(2021, 6, 2, 6, 0, 59), 6, 1'b1, 1'b0, pk(2021, 6, 2, 6, 0, 0)};
      vt[9]  = '{pk(2021, 6, 2, 6, 0, 0), 6, 1'b0, 1'b1, pk(2021, 6, 2, 6, 0, 59)};
      vt[10] = '{pk(2024, 2, 29, 6, 0, 0), 1, 1'b1, 1'b0, pk(2025, 2, 28, 6, 0, 0)};
      vt[11] = '{pk(1, 6, 2, 6, 0, 0), 1, 1'b0, 1'b1, pk(4095, 6, 2, 6, 0, 0)};
      vt[12] = '{pk(2021, 12, 31, 6, 0, 0), 2, 1'b1, 1'b0, pk(2021, 1, 31, 6, 0, 0)};
      vt[13] = '{pk(2021, 1, 31, 6, 0, 0), 3, 1'b1, 1'b0, pk(2021, 1, 1, 6, 0, 0)};
      vt[14] = '{pk(2021, 6, 2, 9, 0, 0), 4, 1'b1, 1'b1, pk(2021, 6, 2, 9, 0, 0)};
      vt[15] = '{pk(2000, 2, 29, 6, 0, 0), 1, 1'b0, 1'b1, pk(1999, 2, 28, 6, 0, 0)};
      vt[16] = '{pk(2021, 3, 31, 6, 0, 0), 2, 1'b0, 1'b1, pk(2021, 2, 28, 6, 0, 0)};

      rst = 1'b1;
      key_mode = 1'b0;
      key_up = 1'b0;
      key_down = 1'b0;
      clk1sec = 1'b0;
      cur_time = pk(2021, 6, 2, 6, 0, 0);
      model_reset();
      #2;
      chk("reset_async", {7'd0, set_time, edit_active, edit_field, bin_time}, {7'd0, 5'd0, RST_BIN});
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_state", {7'd0, set_time, edit_active, edit_field, bin_time}, {7'd0, 5'd0, RST_BIN});

      cyc(0, 1, 0, 0);
      chk("idle_ignores_up", bin_time, RST_BIN);

      cyc(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         cyc(i < 6, 0, 0, 0);
         if (set_time) begin
            pulses++;
            chk("full_commit_bin", bin_time, pk(2024, 6, 2, 6, 0, 0));
            chk("full_commit_field", edit_field, 7);
         end
      end
      chk("full_pulses", pulses, 1);
      chk("full_idle", {edit_active, edit_field}, 0);

      for (int i = 0; i < 17; i++) begin
         do_reset();
         cur_time = vt[i].start;
         cyc(1, 0, 0, 0);
         for (int k = 1; k < vt[i].field; k++) cyc(1, 0, 0, 0);
         cyc(0, vt[i].up, vt[i].dn, 0);
         chk($sformatf("vec%0d_bin", i), bin_time, vt[i].exp);
         chk($sformatf("vec%0d_field", i), edit_field, vt[i].field);
      end

      do_reset();
      cur_time = pk(2030, 3, 4, 5, 6, 7);
      cyc(1, 0, 0, 0);
      for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0, 1);
      chk("tmo_before", edit_field, 1);
      cyc(0, 0, 0, 1);
      chk("tmo_idle", {set_time, edit_active, edit_field}, 0);
      chk("tmo_retained", bin_time, pk(2030, 3, 4, 5, 6, 7));
      cyc(1, 0, 0, 0);
      for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 1);
      chk("tmo_key_wins", edit_field, 1);
      chk("tmo_key_year", bin_time[51:40], 2031);
      for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0, 1);
      chk("tmo_restart", edit_field, 1);
      cyc(0, 0, 0, 1);
      chk("tmo_second", edit_field, 0);

      do_reset();
      cur_time = pk(2021, 6, 2, 6, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      chk("prio_field", edit_field, 2);
      chk("prio_year", bin_time[51:40], 2021);
      cyc(0, 1, 1, 0);
      chk("prio_updown", bin_time, RST_BIN);

      do_reset();
      cur_time = pk(2030, 3, 4, 5, 6, 7);
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
      chk("rst_in_second", edit_field, 6);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_edit", {7'd0, set_time, edit_active, edit_field, bin_time}, {7'd0, 5'd0, RST_BIN});
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0);
         if (set_time) pulses++;
      end
      chk("rst_no_set", pulses, 0);

      do_reset();
      rate = 4;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) rate = int'($urandom_range(2, 24));
         cur_time = rand_time();
         cyc($urandom_range(0, 3 * rate) == 0, $urandom_range(0, rate) == 0,
             $urandom_range(0, rate) == 0, $urandom_range(0, 2) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
